// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// default parameter values, stall-LFSR seed/taps and a saturating counter helper.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WA         = 32;
  localparam int DEF_WD         = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_ADDR_SHIFT = 5;
  localparam int DEF_LATENCY    = 2;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Completion counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_responder_lfsr.sv
// Random stall generator for mem_responder. Only present when
// MEM_RESPONDER_RAND_STALL_EN is defined; otherwise this file is empty.
`ifdef MEM_RESPONDER_RAND_STALL_EN
module mem_responder_lfsr
  import mem_responder_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTX,
  input  logic       ADV,
  output logic [1:0] STALL
);

  logic [15:0] lfsr;
  logic        fb;

  assign fb    = ^(lfsr & LFSR_TAPS);
  // The current value is used by the request being accepted; it then advances.
  assign STALL = lfsr[1:0];

  // Step the sequence once per accepted request.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      lfsr <= LFSR_SEED;
    end else if (ADV) begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

endmodule
`endif

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind an IDLE/BUSY/DONE handshake.
// A request is latched in IDLE, held BUSY for LATENCY cycles, then completed
// in a one-cycle DONE (read data lands in MEMQ, writes commit to storage).
// Optional build macro MEM_RESPONDER_RAND_STALL_EN adds 0..3 random BUSY
// cycles per transaction from a 16-bit LFSR.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WA         = DEF_WA,
  parameter int WD         = DEF_WD,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_SHIFT = DEF_ADDR_SHIFT,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic          CLK,
  input  logic          RSTX,
  input  logic [WA-1:0] MEMA,
  input  logic          MEMRE,
  input  logic          MEMWE,
  input  logic [WD-1:0] MEMD,
  output logic [WD-1:0] MEMQ,
  output logic          MEMBUSY,
  output logic          MEMDONE,
  output logic [15:0]   RDCNT,
  output logic [15:0]   WRCNT
);

  localparam int IW = $clog2(DEPTH);
  // Wide enough for LATENCY-1 (max 14) plus a stall of up to 3.
  localparam int CW = 5;

  logic [WD-1:0] mem [DEPTH];

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] busy_len;
  logic          op_wr;
  logic [IW-1:0] idx_q;
  logic [WD-1:0] wdata_q;
  logic          req;
  logic          accept;
  logic          fin;

  assign req    = MEMRE | MEMWE;
  assign accept = (state == ST_IDLE) && req;
  // Last BUSY cycle: the edge that ends it enters DONE.
  assign fin    = (state == ST_BUSY) && (cnt == '0);

`ifdef MEM_RESPONDER_RAND_STALL_EN
  logic [1:0] stall;

  mem_responder_lfsr u_lfsr (
    .CLK   (CLK),
    .RSTX  (RSTX),
    .ADV   (accept),
    .STALL (stall)
  );

  assign busy_len = CW'(LATENCY - 1) + CW'(stall);
`else
  assign busy_len = CW'(LATENCY - 1);
`endif

  // Control FSM with registered handshake outputs, read data and counters.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      MEMBUSY <= 1'b0;
      MEMDONE <= 1'b0;
      MEMQ    <= '0;
      RDCNT   <= '0;
      WRCNT   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            // Write wins when both requests are raised together.
            op_wr   <= MEMWE;
            cnt     <= busy_len;
            state   <= ST_BUSY;
            MEMBUSY <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state   <= ST_DONE;
            MEMDONE <= 1'b1;
            if (op_wr) begin
              WRCNT <= sat_inc16(WRCNT);
            end else begin
              RDCNT <= sat_inc16(RDCNT);
              MEMQ  <= mem[idx_q];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          MEMBUSY <= 1'b0;
          MEMDONE <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          MEMBUSY <= 1'b0;
          MEMDONE <= 1'b0;
        end
      endcase
    end
  end

  // Capture index and write data of an accepted request; upper address bits wrap away.
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_q   <= IW'(MEMA >> ADDR_SHIFT);
      wdata_q <= MEMD;
    end
  end

  // Storage commit on entry to DONE; a reset during BUSY forces IDLE so nothing commits.
  always_ff @(posedge CLK) begin
    if (fin && op_wr) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WA, 32, address width.
REQ-002 Parameter WD, 32, data width.
REQ-003 Parameter DEPTH, 1024, storage words, power of two.
REQ-004 Parameter ADDR_SHIFT, 5, low MEMA bits dropped to form the word index.
REQ-005 Parameter LATENCY, 2, BUSY-phase cycles, legal range 1..15.
REQ-006 CLK  in  1  sole clock, rising edge.
REQ-007 RSTX  in  1  reset, asynchronous, active-low.
REQ-008 MEMA  in  WA  request address.
REQ-009 MEMRE  in  1  read request, level.
REQ-010 MEMWE  in  1  write request, level.
REQ-011 MEMD  in  WD  write data.
REQ-012 MEMQ  out  WD  read data, registered.
REQ-013 MEMBUSY  out  1  transaction in progress.
REQ-014 MEMDONE  out  1  one-cycle completion pulse.
REQ-015 RDCNT  out  16  completed reads, saturating.
REQ-016 WRCNT  out  16  completed writes, saturating.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-018 In IDLE, with MEMRE or MEMWE sampled high on edge E0, the block SHALL latch the op, the index ((MEMA >> ADDR_SHIFT) mod DEPTH) and MEMD, then enter BUSY.
REQ-019 MEMBUSY SHALL be high in BUSY and DONE and low in IDLE; it therefore rises in the cycle after E0.
REQ-020 BUSY SHALL last exactly LATENCY cycles; DONE SHALL begin after edge E0+LATENCY and last one cycle, then the FSM SHALL return to IDLE.
REQ-021 MEMDONE SHALL be high only in DONE.
REQ-022 A read SHALL load MEMQ with storage[index] on entry to DONE, so MEMQ is valid in the same cycle MEMDONE is high; MEMQ SHALL hold until the next read completes.
REQ-023 A write SHALL commit storage[index] <= latched MEMD on entry to DONE and SHALL leave MEMQ unchanged.
REQ-024 If MEMRE and MEMWE are both high when sampled, the block SHALL perform a write only.
REQ-025 Request inputs SHALL be ignored in BUSY and DONE; the initiator may drop MEMRE/MEMWE at any point after MEMBUSY rises.
REQ-026 A back-to-back request SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-027 RDCNT/WRCNT SHALL increment on entry to DONE for a read/write respectively and saturate at 0xFFFF.
REQ-028 Address bits above the index SHALL be ignored, so indices wrap modulo DEPTH.

Reset
REQ-029 When RSTX is low, the FSM SHALL be in IDLE, with MEMBUSY=0, MEMDONE=0, MEMQ=0, RDCNT=0 and WRCNT=0, taking effect asynchronously.
REQ-030 Reset during BUSY SHALL abort the transaction: no storage commit and no counter update.
REQ-031 Storage contents SHALL NOT be reset.

Configuration
REQ-032 With MEM_RESPONDER_RAND_STALL_EN defined, each transaction SHALL add 0..3 extra BUSY cycles taken from a 16-bit LFSR (seed 0xACE1 on reset, advanced once per accepted request).
REQ-033 Without the macro, BUSY SHALL be exactly LATENCY cycles and no LFSR logic SHALL exist.

Structure
REQ-034 Package mem_responder_pkg SHALL hold the state enum, the default parameter constants and the LFSR seed/taps.
REQ-035 Sub-module mem_responder_lfsr SHALL implement the stall generator and SHALL be instantiated only under the macro.

Verification
REQ-036 Write: LATENCY=2, MEMWE=1, MEMA=0x40, MEMD=0xDEADBEEF at E0 -> MEMBUSY high E0+1..E0+3, MEMDONE high only after E0+2, WRCNT=1.
REQ-037 Read: read of MEMA=0x40 -> MEMQ=0xDEADBEEF in the MEMDONE cycle, held afterwards, RDCNT=1.
REQ-038 Alias: write 0x12345678 at MEMA=0x8000, read MEMA=0x0 -> MEMQ=0x12345678.
REQ-039 Simultaneous: MEMRE=MEMWE=1 with MEMD=0x5 at MEMA=0x20 -> WRCNT+1, RDCNT unchanged, MEMQ unchanged, later read returns 0x5.
REQ-040 Abort: RSTX low one cycle after a write of 0xFFFF0000 to index 3 is accepted -> MEMBUSY=0 immediately, later read of index 3 returns the prior value.
REQ-041 Vector-add style driver: reads at 0x0 and 0x8000, then a write at 0x10000, with MEMRE dropped after MEMBUSY -> all three complete with one MEMDONE each, RDCNT=2, WRCNT=1.
